mips_fetch: RTL and testbench

MIPS_FETCH -- requirements
Module: mips_fetch

---
 rtl/mips_fetch_pkg.sv | 33 +++
 rtl/mips_fetch_if.sv | 63 ++++++
 rtl/mips_fetch_fifo.sv | 60 ++++++
 rtl/mips_fetch.sv | 105 ++++++++++
 tb/tb_mips_fetch.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_fetch_pkg.sv
// Shared fetch/decode definitions: FSM states, FIFO geometry and
// MIPS instruction field positions used by both fetch and decode.
package mips_fetch_pkg;

  localparam int XLEN       = 32;
  localparam int FIFO_DEPTH = 2;
  localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W      = $clog2(FIFO_DEPTH);

  localparam int OPC_HI = 31;
  localparam int OPC_LO = 26;
  localparam int RS_HI  = 25;
  localparam int RS_LO  = 21;
  localparam int RT_HI  = 20;
  localparam int RT_LO  = 16;
  localparam int RD_HI  = 15;
  localparam int RD_LO  = 11;
  localparam int FN_HI  = 5;
  localparam int FN_LO  = 0;
  localparam int IMM_HI = 15;
  localparam int IMM_LO = 0;

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/mips_fetch_if.sv
// Fetch-stage bus: instruction-memory port, decoder handshake and
// exception/halt status, bundled for the fetch unit and its neighbours.
interface mips_fetch_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;

  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [15:0] imm;

  logic        except;
  logic        halted;
  logic [31:0] epc;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_data,
    output out_valid,
    input  out_ready,
    output out_inst,
    output out_pc,
    output opcode,
    output funct,
    output rs,
    output rt,
    output rd,
    output imm,
    input  except,
    output halted,
    output epc
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_data,
    input  out_valid,
    output out_ready,
    input  out_inst,
    input  out_pc,
    input  opcode,
    input  funct,
    input  rs,
    input  rt,
    input  rd,
    input  imm,
    output except,
    input  halted,
    input  epc
  );

endinterface

// File: rtl/mips_fetch_fifo.sv
// Two-entry {pc, inst} queue between the memory response and the
// decoder; flush wins over push/pop in the same cycle.
module fetch_fifo
  import mips_fetch_pkg::*;
(
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic         i_flush,
  input  fetch_entry_t i_data,
  output fetch_entry_t o_head,
  output logic [CNT_W-1:0] o_count
);

  fetch_entry_t     r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr;
  logic [PTR_W-1:0] r_rd;
  logic [CNT_W-1:0] r_count;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;

  assign w_full  = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_empty = (r_count == '0);
  assign w_push  = i_push && !w_full;
  assign w_pop   = i_pop && !w_empty;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_flush) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= i_data;
        r_wr        <= r_wr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd <= r_rd + PTR_W'(1);
      end
      r_count <= r_count
               + CNT_W'(w_push)
               - CNT_W'(w_pop);
    end
  end

  assign o_head  = r_mem[r_rd];
  assign o_count = r_count;

endmodule

// File: rtl/mips_fetch.sv
// MIPS fetch stage: single-outstanding instruction fetch feeding a
// 2-entry queue to the decoder, halting on a decoder exception.
module mips_fetch
  import mips_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h00400000
)(
  input  logic     clock,
  input  logic     reset,
  mips_fetch_if.master bus
);

  fetch_state_e     r_state;
  logic [31:0]      r_pc;
  logic [31:0]      r_req_addr;
  logic             r_inflight;
  logic [31:0]      r_epc;

  fetch_entry_t     w_head;
  fetch_entry_t     w_push_data;
  logic [CNT_W-1:0] w_count;
  logic             w_run;
  logic             w_valid;
  logic             w_pop;
  logic             w_halt;
  logic [2:0]       w_used;
  logic             w_req;

  assign w_run   = (r_state == ST_RUN);
  assign w_valid = w_run && (w_count != '0);
  assign w_pop   = w_valid && bus.out_ready;
  assign w_halt  = w_pop && bus.except;

  // A pop this cycle frees a slot, which keeps one instruction per cycle
  assign w_used = {1'b0, w_count}
                + {2'b00, r_inflight}
                - {2'b00, w_pop};

  assign w_req = !reset && w_run
              && (w_used < 3'(FIFO_DEPTH));

  assign w_push_data.pc   = r_req_addr;
  assign w_push_data.inst = bus.imem_data;

  fetch_fifo u_fifo (
    .i_clk   (clock),
    .i_rst   (reset),
    .i_push  (r_inflight),
    .i_pop   (w_pop),
    .i_flush (w_halt),
    .i_data  (w_push_data),
    .o_head  (w_head),
    .o_count (w_count)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= ST_RUN;
      r_pc       <= RESET_PC & ~32'h3;
      r_req_addr <= '0;
      r_inflight <= 1'b0;
      r_epc      <= '0;
    end else begin
      unique case (r_state)
        ST_RUN: begin
          if (w_halt) begin
            r_state    <= ST_HALT;
            r_epc      <= w_head.pc;
            r_inflight <= 1'b0;
          end else begin
            r_inflight <= w_req;
            if (w_req) begin
              r_req_addr <= r_pc;
              r_pc       <= r_pc + 32'd4;
            end
          end
        end
        ST_HALT: begin
          r_inflight <= 1'b0;
        end
        default: begin
          r_state <= ST_HALT;
        end
      endcase
    end
  end

  assign bus.imem_req  = w_req;
  assign bus.imem_addr = r_pc;

  assign bus.out_valid = w_valid;
  assign bus.out_inst  = w_head.inst;
  assign bus.out_pc    = w_head.pc;

  assign bus.opcode = w_head.inst[OPC_HI:OPC_LO];
  assign bus.funct  = w_head.inst[FN_HI:FN_LO];
  assign bus.rs     = w_head.inst[RS_HI:RS_LO];
  assign bus.rt     = w_head.inst[RT_HI:RT_LO];
  assign bus.rd     = w_head.inst[RD_HI:RD_LO];
  assign bus.imm    = w_head.inst[IMM_HI:IMM_LO];

  assign bus.halted = (r_state == ST_HALT);
  assign bus.epc    = r_epc;

endmodule

// File: tb/tb_mips_fetch.sv
// Directed bench for mips_fetch with a stream-order reference model
// and a second instance exercising the PC wrap-around.
module tb_mips_fetch;

  localparam logic [31:0] K      = 32'hA5A5A5A5;
  localparam logic [31:0] RPC_A  = 32'h00400000;
  localparam logic [31:0] RPC_B  = 32'hFFFFFFF8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ra  = 1'b0;
  logic ea  = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mips_fetch_if ia ();
  mips_fetch_if ib ();

  mips_fetch #(.RESET_PC(RPC_A)) dut_a (
    .clock (clk),
    .reset (rst),
    .bus   (ia)
  );

  mips_fetch #(.RESET_PC(RPC_B)) dut_b (
    .clock (clk),
    .reset (rst),
    .bus   (ib)
  );

  logic [31:0] ma = '0;
  logic [31:0] mb = '0;

  always @(posedge clk) begin
    ma <= ia.imem_addr ^ K;
    mb <= ib.imem_addr ^ K;
  end

  assign ia.imem_data = ma;
  assign ia.out_ready = ra;
  assign ia.except    = ea;
  assign ib.imem_data = mb;
  assign ib.out_ready = 1'b1;
  assign ib.except    = 1'b0;

  task automatic check(input string nm,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h want %h", nm, got, exp);
    end
  endtask

  // Reference model: instructions leave in program order, one per accept
  logic [31:0] m_next = RPC_A;
  logic        m_halt = 1'b0;
  logic [31:0] m_epc  = '0;
  logic        p_stall = 1'b0;
  logic [31:0] p_pc   = '0;
  logic [31:0] qb [$];

  always @(negedge clk) begin
    logic [31:0] e;
    if (rst) begin
      check("rst_req", ia.imem_req, 0);
      check("rst_valid", ia.out_valid, 0);
      check("rst_halted", ia.halted, 0);
      check("rst_epc", ia.epc, 0);
      check("rst_req_b", ib.imem_req, 0);
      m_next  = RPC_A;
      m_halt  = 1'b0;
      m_epc   = '0;
      p_stall = 1'b0;
      qb.delete();
    end else begin
      if (m_halt) begin
        check("h_halted", ia.halted, 1);
        check("h_valid", ia.out_valid, 0);
        check("h_req", ia.imem_req, 0);
        check("h_epc", ia.epc, m_epc);
      end else begin
        check("r_halted", ia.halted, 0);
        if (p_stall) begin
          check("hold_valid", ia.out_valid, 1);
          check("hold_pc", ia.out_pc, p_pc);
        end
        if (ia.imem_req) begin
          check("align", {30'd0, ia.imem_addr[1:0]}, 0);
        end
        if (ia.out_valid) begin
          e = m_next ^ K;
          check("m_pc", ia.out_pc, m_next);
          check("m_inst", ia.out_inst, e);
          check("m_opc", {26'd0, ia.opcode}, {26'd0, e[31:26]});
          check("m_rs", {27'd0, ia.rs}, {27'd0, e[25:21]});
          check("m_rt", {27'd0, ia.rt}, {27'd0, e[20:16]});
          check("m_rd", {27'd0, ia.rd}, {27'd0, e[15:11]});
          check("m_fn", {26'd0, ia.funct}, {26'd0, e[5:0]});
          check("m_imm", {16'd0, ia.imm}, {16'd0, e[15:0]});
          if (ra) begin
            if (ea) begin
              m_halt = 1'b1;
              m_epc  = m_next;
            end else begin
              m_next = m_next + 32'd4;
            end
          end
        end
        p_stall = ia.out_valid && !ra;
        p_pc    = ia.out_pc;
      end
      if (ib.out_valid) begin
        check("b_inst", ib.out_inst, ib.out_pc ^ K);
        qb.push_back(ib.out_pc);
      end
    end
  end

  task automatic step(input logic r,
                      input logic rdy,
                      input logic exc);
    @(posedge clk);
    #1;
    rst = r;
    ra  = rdy;
    ea  = exc;
    #3;
  endtask

  initial begin
    int nreq;
    bit hit;
    repeat (3) step(1, 0, 0);
    check("d_rst_req", ia.imem_req, 0);
    check("d_rst_valid", ia.out_valid, 0);

    step(0, 1, 0);
    check("c0_req", ia.imem_req, 1);
    check("c0_addr", ia.imem_addr, 32'h00400000);
    check("c0_valid", ia.out_valid, 0);
    step(0, 1, 0);
    check("c1_req", ia.imem_req, 1);
    check("c1_addr", ia.imem_addr, 32'h00400004);
    check("c1_valid", ia.out_valid, 0);
    step(0, 1, 0);
    check("c2_valid", ia.out_valid, 1);
    check("c2_pc", ia.out_pc, 32'h00400000);
    check("c2_inst", ia.out_inst, 32'hA5E5A5A5);
    check("c2_opc", {26'd0, ia.opcode}, 32'h29);
    check("c2_fn", {26'd0, ia.funct}, 32'h25);
    check("c2_rs", {27'd0, ia.rs}, 32'd15);
    check("c2_rt", {27'd0, ia.rt}, 32'd5);
    check("c2_rd", {27'd0, ia.rd}, 32'd20);
    check("c2_imm", {16'd0, ia.imm}, 32'hA5A5);
    step(0, 1, 0);
    check("c3_valid", ia.out_valid, 1);
    check("c3_pc", ia.out_pc, 32'h00400004);
    step(0, 1, 0);
    check("c4_valid", ia.out_valid, 1);
    check("c4_pc", ia.out_pc, 32'h00400008);

    step(1, 0, 0);
    nreq = 0;
    for (int i = 0; i < 7; i++) begin
      step(0, 0, i == 4);
      if (ia.imem_req) nreq++;
      if (i >= 2) begin
        check("stall_valid", ia.out_valid, 1);
        check("stall_pc", ia.out_pc, 32'h00400000);
      end
      if (i == 5) check("noready_exc", ia.halted, 0);
    end
    check("stall_nreq", nreq, 2);

    step(0, 1, 0);
    check("c7_pc", ia.out_pc, 32'h00400000);
    check("c7_req", ia.imem_req, 1);
    check("c7_addr", ia.imem_addr, 32'h00400008);
    step(0, 1, 0);
    check("c8_pc", ia.out_pc, 32'h00400004);

    hit = 1'b0;
    for (int i = 0; i < 10 && !hit; i++) begin
      @(posedge clk);
      #1;
      hit = ia.out_valid && (ia.out_pc == 32'h00400008);
      ra  = 1'b1;
      ea  = hit;
      #3;
    end
    check("find_pc8", {31'd0, hit}, 1);
    step(0, 1, 0);
    check("x_halted", ia.halted, 1);
    check("x_epc", ia.epc, 32'h00400008);
    check("x_valid", ia.out_valid, 0);
    check("x_req", ia.imem_req, 0);
    nreq = 0;
    repeat (3) begin
      step(0, 1, 0);
      if (ia.imem_req || ia.out_valid) nreq++;
    end
    check("x_quiet", nreq, 0);

    step(1, 1, 0);
    repeat (4) step(0, 1, 0);
    check("pre_rst_req", ia.imem_req, 1);
    step(1, 1, 0);
    check("mid_rst_req", ia.imem_req, 0);
    step(0, 1, 0);
    check("post_req", ia.imem_req, 1);
    check("post_addr", ia.imem_addr, 32'h00400000);
    hit = 1'b0;
    for (int i = 0; i < 5 && !hit; i++) begin
      step(0, 1, 0);
      hit = ia.out_valid;
    end
    check("post_seen", {31'd0, hit}, 1);
    check("post_pc", ia.out_pc, 32'h00400000);
    repeat (6) step(0, 1, 0);

    check("b_count", {31'd0, qb.size() >= 3}, 1);
    if (qb.size() >= 3) begin
      check("b_pc0", qb[0], 32'hFFFFFFF8);
      check("b_pc1", qb[1], 32'hFFFFFFFC);
      check("b_pc2", qb[2], 32'h00000000);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule
